mem_seq: RTL
============

# mem_seq

Memory-side initiator that drives the byte-wide, 256-deep data memory port (combinational read, clocked write) to run block operations without the core. On a start pulse it copies `len` bytes from `src_addr` to `dst_addr`, or fills `len` bytes at `dst_addr` with a constant. It sits between the control unit and the data memory and owns the memory port while busy; the core's memory port is muxed out whenever `busy` is high.

## Interface
- `ADDR_W`, 8: address / length width; memory depth is 2^ADDR_W.
- `DATA_W`, 8: data byte width.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `mode`  in  1  0 = copy, 1 = fill; sampled with `start`.
- `src_addr`  in  ADDR_W  copy source base; sampled with `start`.
- `dst_addr`  in  ADDR_W  destination base; sampled with `start`.
- `len`  in  ADDR_W  byte count, 0..255; 0 = no-op; sampled with `start`.
- `fill_val`  in  DATA_W  fill byte; sampled with `start`.
- `mem_dat_in`  in  DATA_W  memory read data (memory `dat_out`).
- `mem_addr`  out  ADDR_W  memory address.
- `mem_rd_en`  out  1  high in read cycles.
- `mem_wr_en`  out  1  high in write cycles.
- `mem_dat_out`  out  DATA_W  write data (memory `dat_in`).
- `busy`  out  1  high while operation in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE: all outputs 0. On `start`=1: latch `mode`, `src_addr`, `dst_addr`, `len`, `fill_val` into internal regs. len=0 → DONE. Else copy → RD, fill → WR.
- RD (copy only): `mem_addr`=src pointer, `mem_rd_en`=1. At the clock edge, capture `mem_dat_in` into the hold reg and increment the src pointer. → WR.
- WR: `mem_addr`=dst pointer, `mem_wr_en`=1, `mem_dat_out`=hold reg (copy) or latched `fill_val` (fill). At the edge: increment dst pointer, decrement remaining count. If remaining becomes 0 → DONE; else copy → RD, fill → WR.
- DONE: `done`=1, `busy`=0, memory outputs 0. → IDLE unconditionally.
- Pointers wrap modulo 2^ADDR_W: 255+1=0. There is no bounds error.
- Copy is always ascending, byte by byte, read before write. With overlapping regions and dst>src, already-written bytes are re-read. This is the defined behaviour, not an error.
- `start` in RD, WR or DONE is ignored; it is not queued.
- Input changes after the start cycle have no effect.
- Port outputs are registered-state decodes. `mem_wr_en` and `mem_rd_en` are never high together.

## Timing
- Reset values: state=IDLE. `busy`, `done`, `mem_rd_en`, `mem_wr_en`, `mem_addr` and `mem_dat_out` are all 0. Internal pointers, count and hold reg are 0.
- Start sampled at edge E0. The first RD or WR cycle is E0→E1, and `busy` goes high in that cycle.
- Copy of L bytes: byte k (0-based) reads in cycle 2k+1 and writes in cycle 2k+2. `done` is high in cycle 2L+1. The next `start` is accepted in cycle 2L+2.
- Fill of L bytes: byte k is written in cycle k+1. `done` is high in cycle L+1.
- len=0: `done` is high in cycle 1, `busy` never rises, no memory access.
- Read data is sampled at the end of the RD cycle, which relies on the memory's combinational read.
- `reset` mid-operation: at the next edge, return to IDLE with all outputs 0. Bytes already written remain; there is no `done` pulse.

## Test plan
- Copy: mem[0x10..0x13]=A1,B2,C3,D4; start copy src=0x10 dst=0x80 len=4 → mem[0x80..0x83]=A1,B2,C3,D4; `done` high exactly at cycle 9; `busy` high cycles 1–8; source unchanged.
- Fill with wrap: fill dst=0xFE len=3 val=0x5A → mem[0xFE], mem[0xFF] and mem[0x00] = 0x5A; mem[0x01] unchanged; `done` at cycle 4.
- Overlap: mem[0x20]=11, mem[0x21]=22; copy src=0x20 dst=0x21 len=2 → mem[0x21]=11, mem[0x22]=11.
- No-op: len=0 → `done` at cycle 1; `mem_wr_en` and `mem_rd_en` never high; `busy` stays 0.
- Ignored start: re-pulse `start` with a different dst mid-copy → only the original transfer occurs, one `done` pulse.
- Reset mid-copy: len=8, assert `reset` at cycle 5 → idle with all outputs 0 next cycle; only the first 2 bytes are written; no `done`; a fresh start then completes normally.

Source files
------------

// File: rtl/mem_seq.sv
// ---------------------------------------------------------------------------
// mem_seq -- block-transfer sequencer for the byte-wide data memory port.
//
// While busy it owns the memory port and runs one of two operations:
//   copy : len bytes from src_addr to dst_addr, ascending, one read then one
//          write per byte (2 cycles/byte)
//   fill : len bytes at dst_addr written with fill_val (1 cycle/byte)
// Addresses wrap modulo 2^ADDR_W. len = 0 gives a single done pulse and
// makes no memory access.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        command strobe, sampled only in IDLE
//   mode         0 = copy, 1 = fill (sampled with start)
//   src_addr     copy source base (sampled with start)
//   dst_addr     destination base (sampled with start)
//   len          byte count, 0 = no-op (sampled with start)
//   fill_val     fill byte (sampled with start)
//   mem_dat_in   memory read data (combinational read)
//   mem_addr     memory address
//   mem_rd_en    high in read cycles
//   mem_wr_en    high in write cycles
//   mem_dat_out  memory write data
//   busy         high while a transfer is in progress
//   done         one-cycle completion pulse
// ---------------------------------------------------------------------------
module mem_seq #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W-1:0] len,
   input  logic [DATA_W-1:0] fill_val,
   input  logic [DATA_W-1:0] mem_dat_in,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [DATA_W-1:0] mem_dat_out,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state;
   state_t            state_nx;

   // Command registers captured on the accepted start.
   logic              mode_q;      // 0 = copy, 1 = fill
   logic [DATA_W-1:0] fill_q;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [ADDR_W-1:0] cnt;         // bytes still to be written
   logic [DATA_W-1:0] hold;        // byte read in RD, written in the next WR

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         mode_q  <= 1'b0;
         fill_q  <= '0;
         src_ptr <= '0;
         dst_ptr <= '0;
         cnt     <= '0;
         hold    <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (start) begin
                  mode_q  <= mode;
                  fill_q  <= fill_val;
                  src_ptr <= src_addr;
                  dst_ptr <= dst_addr;
                  cnt     <= len;
               end
            end
            RD: begin
               // Combinational memory read: data is valid within this cycle.
               hold    <= mem_dat_in;
               src_ptr <= src_ptr + PTR_ONE;
            end
            WR: begin
               dst_ptr <= dst_ptr + PTR_ONE;
               cnt     <= cnt - PTR_ONE;
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Next state and output decode (outputs depend on registered state only)
   // -------------------------------------------------------------------------
   // NOTE: every output and state_nx gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_nx    = state;
      mem_addr    = '0;
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
      mem_dat_out = '0;
      busy        = 1'b0;
      done        = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               if (len == '0)
                  state_nx = DONE;
               else if (mode)
                  state_nx = WR;
               else
                  state_nx = RD;
            end
         end
         RD: begin
            busy      = 1'b1;
            mem_addr  = src_ptr;
            mem_rd_en = 1'b1;
            state_nx  = WR;
         end
         WR: begin
            busy        = 1'b1;
            mem_addr    = dst_ptr;
            mem_wr_en   = 1'b1;
            mem_dat_out = mode_q ? fill_q : hold;
            // cnt is decremented at this edge; reaching zero ends the run.
            if (cnt == PTR_ONE)
               state_nx = DONE;
            else if (mode_q)
               state_nx = WR;
            else
               state_nx = RD;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule
